// File: rtl/level_sequencer.sv
// Game-flow controller: walks the level table, drives the destination rectangle,
// and runs the per-attempt countdown and the lives counter.
module level_sequencer #(
  parameter int unsigned NUM_LEVELS   = 4,
  parameter int unsigned LIVES        = 3,
  parameter int unsigned TIME_LIMIT   = 60,
  parameter int unsigned PAUSE_CYCLES = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sec_tick,
  input  logic        level_complete,
  output logic [11:0] dest_hPos,
  output logic [11:0] dest_vPos,
  output logic [3:0]  dest_color,
  output logic        dest_visible,
  output logic        player_reset,
  output logic [1:0]  level,
  output logic [1:0]  lives,
  output logic [7:0]  time_left,
  output logic        game_over,
  output logic        game_won,
  output logic [2:0]  state
);

  localparam int unsigned PCW = 25;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    LOST  = 3'd4,
    WON   = 3'd5
  } state_t;

  state_t         st;
  logic [PCW-1:0] pause_cnt;
  logic [11:0]    rom_h;
  logic [11:0]    rom_v;
  logic [3:0]     rom_c;

  assign state = st;

  // Level table: destination position and color per level
  always_comb begin
    rom_h = 12'd100;
    rom_v = 12'd100;
    rom_c = 4'h2;
    case (level)
      2'd1: begin rom_h = 12'd500; rom_v = 12'd60;  rom_c = 4'h4; end
      2'd2: begin rom_h = 12'd40;  rom_v = 12'd420; rom_c = 4'h6; end
      2'd3: begin rom_h = 12'd600; rom_v = 12'd440; rom_c = 4'hA; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st           <= IDLE;
      level        <= '0;
      lives        <= '0;
      time_left    <= '0;
      dest_hPos    <= '0;
      dest_vPos    <= '0;
      dest_color   <= '0;
      dest_visible <= 1'b0;
      player_reset <= 1'b0;
      game_over    <= 1'b0;
      game_won     <= 1'b0;
      pause_cnt    <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (start) begin
            level <= '0;
            lives <= 2'(LIVES);
            st    <= LOAD;
          end
        end

        LOAD: begin
          dest_hPos    <= rom_h;
          dest_vPos    <= rom_v;
          dest_color   <= rom_c;
          time_left    <= 8'(TIME_LIMIT);
          dest_visible <= 1'b1;
          player_reset <= 1'b1;
          st           <= PLAY;
        end

        PLAY: begin
          player_reset <= 1'b0;
          // level_complete takes priority over a coincident timeout
          if (level_complete) begin
            pause_cnt    <= '0;
            dest_visible <= 1'b0;
            st           <= PAUSE;
          end else if (sec_tick) begin
            if (time_left > 8'd1) begin
              time_left <= time_left - 8'd1;
            end else if (time_left == 8'd1) begin
              time_left <= '0;
              if (lives > 2'd1) begin
                lives <= lives - 2'd1;
                st    <= LOAD;
              end else begin
                lives        <= '0;
                dest_visible <= 1'b0;
                game_over    <= 1'b1;
                st           <= LOST;
              end
            end
          end
        end

        PAUSE: begin
          dest_visible <= 1'b0;
          if (pause_cnt == PCW'(PAUSE_CYCLES - 1)) begin
            if (level == 2'(NUM_LEVELS - 1)) begin
              game_won <= 1'b1;
              st       <= WON;
            end else begin
              level <= level + 2'd1;
              st    <= LOAD;
            end
          end else begin
            pause_cnt <= pause_cnt + PCW'(1);
          end
        end

        LOST, WON: begin
          dest_visible <= 1'b0;
          if (start) begin
            level     <= '0;
            lives     <= 2'(LIVES);
            game_over <= 1'b0;
            game_won  <= 1'b0;
            st        <= LOAD;
          end
        end

        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_level_sequencer.sv
// Directed table-driven bench for level_sequencer with short pause and time limit.
module tb_level_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        sec_tick = 1'b0;
  logic        level_complete = 1'b0;
  logic [11:0] dest_hPos;
  logic [11:0] dest_vPos;
  logic [3:0]  dest_color;
  logic        dest_visible;
  logic        player_reset;
  logic [1:0]  level;
  logic [1:0]  lives;
  logic [7:0]  time_left;
  logic        game_over;
  logic        game_won;
  logic [2:0]  state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  level_sequencer #(
    .NUM_LEVELS(4), .LIVES(3), .TIME_LIMIT(3), .PAUSE_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sec_tick(sec_tick),
    .level_complete(level_complete),
    .dest_hPos(dest_hPos), .dest_vPos(dest_vPos), .dest_color(dest_color),
    .dest_visible(dest_visible), .player_reset(player_reset),
    .level(level), .lives(lives), .time_left(time_left),
    .game_over(game_over), .game_won(game_won), .state(state)
  );

  typedef struct {
    logic [3:0]  in;     // {rst, start, sec_tick, level_complete}
    logic [2:0]  st;
    logic [1:0]  lvl;
    logic [1:0]  lv;
    logic [7:0]  tl;
    logic [3:0]  flags;  // {dest_visible, player_reset, game_over, game_won}
    logic [11:0] h;
    logic [11:0] v;
    logic [3:0]  c;
  } vec_t;

  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_PLAY = 3'd2,
                         S_PAUSE = 3'd3, S_LOST = 3'd4, S_WON = 3'd5;

  logic [11:0] exp_h [4] = '{12'd100, 12'd500, 12'd40, 12'd600};
  logic [11:0] exp_v [4] = '{12'd100, 12'd60, 12'd420, 12'd440};
  logic [3:0]  exp_c [4] = '{4'h2, 4'h4, 4'h6, 4'hA};

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] in, input logic [2:0] st,
                              input logic [1:0] lvl, input logic [1:0] lv,
                              input logic [7:0] tl, input logic [3:0] flags,
                              input logic [11:0] h, input logic [11:0] v,
                              input logic [3:0] c);
    vec_t r;
    r.in = in; r.st = st; r.lvl = lvl; r.lv = lv; r.tl = tl;
    r.flags = flags; r.h = h; r.v = v; r.c = c;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs, clock one edge, then sample 1 ns later
  task automatic apply(input logic [3:0] in);
    {rst, start, sec_tick, level_complete} = in;
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string tag, input vec_t e);
    check({tag, ".state"},        32'(state),        32'(e.st));
    check({tag, ".level"},        32'(level),        32'(e.lvl));
    check({tag, ".lives"},        32'(lives),        32'(e.lv));
    check({tag, ".time_left"},    32'(time_left),    32'(e.tl));
    check({tag, ".dest_visible"}, 32'(dest_visible), 32'(e.flags[3]));
    check({tag, ".player_reset"}, 32'(player_reset), 32'(e.flags[2]));
    check({tag, ".game_over"},    32'(game_over),    32'(e.flags[1]));
    check({tag, ".game_won"},     32'(game_won),     32'(e.flags[0]));
    check({tag, ".dest_hPos"},    32'(dest_hPos),    32'(e.h));
    check({tag, ".dest_vPos"},    32'(dest_vPos),    32'(e.v));
    check({tag, ".dest_color"},   32'(dest_color),   32'(e.c));
  endtask

  task automatic step(input string tag, input vec_t e);
    apply(e.in);
    check_vec(tag, e);
  endtask

  initial begin
    // Reset, start, level advance, timeouts, collision, loss and restart
    tbl.push_back(mk(4'b0000, S_IDLE,  0, 0, 0, 4'b0000,   0,   0, 0));
    tbl.push_back(mk(4'b1000, S_IDLE,  0, 0, 0, 4'b0000,   0,   0, 0));
    tbl.push_back(mk(4'b1100, S_LOAD,  0, 3, 0, 4'b0000,   0,   0, 0));
    tbl.push_back(mk(4'b1000, S_PLAY,  0, 3, 3, 4'b1100, 100, 100, 2));
    tbl.push_back(mk(4'b1000, S_PLAY,  0, 3, 3, 4'b1000, 100, 100, 2));
    tbl.push_back(mk(4'b1100, S_PLAY,  0, 3, 3, 4'b1000, 100, 100, 2));
    tbl.push_back(mk(4'b1001, S_PAUSE, 0, 3, 3, 4'b0000, 100, 100, 2));
    tbl.push_back(mk(4'b1001, S_PAUSE, 0, 3, 3, 4'b0000, 100, 100, 2));
    tbl.push_back(mk(4'b1000, S_PAUSE, 0, 3, 3, 4'b0000, 100, 100, 2));
    tbl.push_back(mk(4'b1000, S_PAUSE, 0, 3, 3, 4'b0000, 100, 100, 2));
    tbl.push_back(mk(4'b1000, S_LOAD,  1, 3, 3, 4'b0000, 100, 100, 2));
    tbl.push_back(mk(4'b1000, S_PLAY,  1, 3, 3, 4'b1100, 500,  60, 4));
    tbl.push_back(mk(4'b1010, S_PLAY,  1, 3, 2, 4'b1000, 500,  60, 4));
    tbl.push_back(mk(4'b1010, S_PLAY,  1, 3, 1, 4'b1000, 500,  60, 4));
    tbl.push_back(mk(4'b1010, S_LOAD,  1, 2, 0, 4'b1000, 500,  60, 4));
    tbl.push_back(mk(4'b1000, S_PLAY,  1, 2, 3, 4'b1100, 500,  60, 4));
    tbl.push_back(mk(4'b1010, S_PLAY,  1, 2, 2, 4'b1000, 500,  60, 4));
    tbl.push_back(mk(4'b1010, S_PLAY,  1, 2, 1, 4'b1000, 500,  60, 4));
    tbl.push_back(mk(4'b1011, S_PAUSE, 1, 2, 1, 4'b0000, 500,  60, 4));
    tbl.push_back(mk(4'b1000, S_PAUSE, 1, 2, 1, 4'b0000, 500,  60, 4));
    tbl.push_back(mk(4'b1000, S_PAUSE, 1, 2, 1, 4'b0000, 500,  60, 4));
    tbl.push_back(mk(4'b1000, S_PAUSE, 1, 2, 1, 4'b0000, 500,  60, 4));
    tbl.push_back(mk(4'b1000, S_LOAD,  2, 2, 1, 4'b0000, 500,  60, 4));
    tbl.push_back(mk(4'b1000, S_PLAY,  2, 2, 3, 4'b1100,  40, 420, 6));
    tbl.push_back(mk(4'b1010, S_PLAY,  2, 2, 2, 4'b1000,  40, 420, 6));
    tbl.push_back(mk(4'b1010, S_PLAY,  2, 2, 1, 4'b1000,  40, 420, 6));
    tbl.push_back(mk(4'b1010, S_LOAD,  2, 1, 0, 4'b1000,  40, 420, 6));
    tbl.push_back(mk(4'b1000, S_PLAY,  2, 1, 3, 4'b1100,  40, 420, 6));
    tbl.push_back(mk(4'b1010, S_PLAY,  2, 1, 2, 4'b1000,  40, 420, 6));
    tbl.push_back(mk(4'b1010, S_PLAY,  2, 1, 1, 4'b1000,  40, 420, 6));
    tbl.push_back(mk(4'b1010, S_LOST,  2, 0, 0, 4'b0010,  40, 420, 6));
    tbl.push_back(mk(4'b1010, S_LOST,  2, 0, 0, 4'b0010,  40, 420, 6));
    tbl.push_back(mk(4'b1100, S_LOAD,  0, 3, 0, 4'b0000,  40, 420, 6));
    tbl.push_back(mk(4'b1000, S_PLAY,  0, 3, 3, 4'b1100, 100, 100, 2));

    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("row%0d", i), tbl[i]);

    // Full win from level 0 through level 3, then restart
    for (int l = 0; l < 4; l++) begin
      step($sformatf("win%0d_lc", l),
           mk(4'b1001, S_PAUSE, 2'(l), 3, 3, 4'b0000, exp_h[l], exp_v[l], exp_c[l]));
      for (int k = 1; k < 4; k++)
        step($sformatf("win%0d_pause%0d", l, k),
             mk(4'b1000, S_PAUSE, 2'(l), 3, 3, 4'b0000, exp_h[l], exp_v[l], exp_c[l]));
      if (l < 3) begin
        step($sformatf("win%0d_load", l),
             mk(4'b1000, S_LOAD, 2'(l + 1), 3, 3, 4'b0000, exp_h[l], exp_v[l], exp_c[l]));
        step($sformatf("win%0d_play", l),
             mk(4'b1000, S_PLAY, 2'(l + 1), 3, 3, 4'b1100,
                exp_h[l + 1], exp_v[l + 1], exp_c[l + 1]));
      end else begin
        step("win_done", mk(4'b1000, S_WON, 3, 3, 3, 4'b0001, exp_h[3], exp_v[3], exp_c[3]));
        step("win_hold", mk(4'b1010, S_WON, 3, 3, 3, 4'b0001, exp_h[3], exp_v[3], exp_c[3]));
      end
    end
    step("restart_load", mk(4'b1100, S_LOAD, 0, 3, 3, 4'b0000, exp_h[3], exp_v[3], exp_c[3]));
    step("restart_play", mk(4'b1000, S_PLAY, 0, 3, 3, 4'b1100, 100, 100, 2));

    // Reset mid-pause with the pause counter at 2; reset overrides start
    step("mr_lc",  mk(4'b1001, S_PAUSE, 0, 3, 3, 4'b0000, 100, 100, 2));
    step("mr_p1",  mk(4'b1000, S_PAUSE, 0, 3, 3, 4'b0000, 100, 100, 2));
    step("mr_p2",  mk(4'b1000, S_PAUSE, 0, 3, 3, 4'b0000, 100, 100, 2));
    step("mr_rst", mk(4'b0100, S_IDLE,  0, 0, 0, 4'b0000,   0,   0, 0));
    step("mr_idle", mk(4'b1000, S_IDLE, 0, 0, 0, 4'b0000,   0,   0, 0));
    step("mr_load", mk(4'b1100, S_LOAD, 0, 3, 0, 4'b0000,   0,   0, 0));
    step("mr_play", mk(4'b1000, S_PLAY, 0, 3, 3, 4'b1100, 100, 100, 2));
    step("mr_lc2",  mk(4'b1001, S_PAUSE, 0, 3, 3, 4'b0000, 100, 100, 2));
    for (int k = 1; k < 4; k++)
      step($sformatf("mr_pause%0d", k), mk(4'b1000, S_PAUSE, 0, 3, 3, 4'b0000, 100, 100, 2));
    step("mr_load2", mk(4'b1000, S_LOAD, 1, 3, 3, 4'b0000, 100, 100, 2));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
